pixel_writeback_arbiter: RTL and testbench

//  Collects escape-iteration results from NUM_LANES Mandelbrot iterator lanes and maps each to an 8-bit RGB332 colour.

---
 rtl/pixel_writeback_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_pixel_writeback_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_writeback_arbiter
//
// Collects escape-iteration results from NUM_LANES Mandelbrot iterator lanes,
// converts each one to an 8-bit RGB332 colour and writes it into the VGA SRAM
// through its Avalon slave port. Lanes are served round-robin, one grant per
// cycle. A two-stage pipeline (grant, then write) sustains one SRAM write per
// clock. Each lane owns an interleaved column of pixels in the frame:
//     address = base_addr + lane + NUM_LANES * pixel_index_of_lane
// A frame is opened with start. done is raised, and held, once every lane has
// delivered PIXELS_PER_LANE results and the last write has left the pipeline.
//
// Ports
//   clk             in   clock
//   rst             in   synchronous reset, active-high
//   start           in   begin a frame (sampled only in IDLE and DONE)
//   base_addr       in   SRAM address of pixel 0 (held stable during a frame)
//   max_iterations  in   iteration cap for the colour map (held stable)
//   res_valid       in   per-lane "result available"
//   res_iter        in   per-lane iteration count, lane k at [k*ITER_W +: ITER_W]
//   res_ack         out  one-cycle accept pulse back to each lane
//   sram_address    out  SRAM write address
//   sram_writedata  out  RGB332 pixel
//   sram_write      out  write strobe
//   sram_clken      out  tied to 1
//   sram_chipselect out  tied to 1
//   busy            out  high while a frame is in progress
//   done            out  high once the frame is complete, held until restart
//   overflow        out  sticky: a lane offered a result after finishing
// ---------------------------------------------------------------------------
module pixel_writeback_arbiter #(
    parameter int NUM_LANES       = 4,
    parameter int ITER_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int PIXELS_PER_LANE = 76800,
    parameter int CNT_W           = $clog2(PIXELS_PER_LANE + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [ITER_W-1:0]           max_iterations,
    input  logic [NUM_LANES-1:0]        res_valid,
    input  logic [NUM_LANES*ITER_W-1:0] res_iter,
    output logic [NUM_LANES-1:0]        res_ack,
    output logic [ADDR_W-1:0]           sram_address,
    output logic [7:0]                  sram_writedata,
    output logic                        sram_write,
    output logic                        sram_clken,
    output logic                        sram_chipselect,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int              LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIXELS_PER_LANE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state;

    // Per-lane count of pixels already written this frame.
    logic [CNT_W-1:0]  cnt [NUM_LANES];
    // Lane at which the next round-robin search begins.
    logic [LANE_W-1:0] ptr;

    // Grant stage: lane, its result and its pixel index, waiting to be written.
    logic              pending;
    logic [LANE_W-1:0] lat_lane;
    logic [ITER_W-1:0] lat_iter;
    logic [CNT_W-1:0]  lat_cnt;

    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] exhausted_valid;
    logic                 all_full;

    logic                 grant_valid;
    logic [LANE_W-1:0]    grant_lane;
    logic [ITER_W-1:0]    grant_iter;
    logic [CNT_W-1:0]     grant_cnt;
    logic [NUM_LANES-1:0] grant_onehot;
    logic [LANE_W-1:0]    ptr_next;

    assign sram_clken      = 1'b1;
    assign sram_chipselect = 1'b1;

    // RGB332 colour map: compare against successively halved caps, first
    // match wins. A cap of zero makes the first test always true (black).
    function automatic logic [7:0] rgb332(input logic [ITER_W-1:0] it,
                                          input logic [ITER_W-1:0] m);
        logic [7:0] c;
        if (it >= m)              c = 8'h00;
        else if (it >= (m >> 1))  c = 8'h64;
        else if (it >= (m >> 2))  c = 8'h64;
        else if (it >= (m >> 3))  c = 8'hA9;
        else if (it >= (m >> 4))  c = 8'h65;
        else if (it >= (m >> 5))  c = 8'h25;
        else if (it >= (m >> 6))  c = 8'h6A;
        else                      c = 8'h92;
        return c;
    endfunction

    // A lane whose ack is high in this cycle is still showing the result that
    // was just accepted, so it must be skipped or it would be written twice.
    always_comb begin
        all_full = 1'b1;
        for (int k = 0; k < NUM_LANES; k++) begin
            eligible[k]        = res_valid[k] && (cnt[k] < CNT_FULL) && !res_ack[k];
            exhausted_valid[k] = res_valid[k] && (cnt[k] == CNT_FULL);
            if (cnt[k] != CNT_FULL) begin
                all_full = 1'b0;
            end
        end
    end

    // Round-robin search in two passes: lanes at or above ptr first, then
    // wrap to the lowest-numbered eligible lane.
    always_comb begin
        grant_valid  = 1'b0;
        grant_lane   = '0;
        grant_iter   = '0;
        grant_cnt    = '0;
        grant_onehot = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!grant_valid && eligible[k] && (k >= int'(ptr))) begin
                grant_valid     = 1'b1;
                grant_lane      = LANE_W'(k);
                grant_iter      = res_iter[k*ITER_W +: ITER_W];
                grant_cnt       = cnt[k];
                grant_onehot[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!grant_valid && eligible[k]) begin
                grant_valid     = 1'b1;
                grant_lane      = LANE_W'(k);
                grant_iter      = res_iter[k*ITER_W +: ITER_W];
                grant_cnt       = cnt[k];
                grant_onehot[k] = 1'b1;
            end
        end
    end

    assign ptr_next = (grant_lane == LANE_W'(NUM_LANES - 1)) ? '0
                                                             : grant_lane + LANE_W'(1);

    // Frame FSM with the grant and write pipeline stages. Every output is
    // registered here so the SRAM and lanes see clean, glitch-free signals.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            res_ack        <= '0;
            sram_write     <= 1'b0;
            sram_address   <= '0;
            sram_writedata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            ptr            <= '0;
            pending        <= 1'b0;
            lat_lane       <= '0;
            lat_iter       <= '0;
            lat_cnt        <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    res_ack    <= '0;
                    sram_write <= 1'b0;
                    pending    <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        ptr      <= '0;
                        for (int k = 0; k < NUM_LANES; k++) begin
                            cnt[k] <= '0;
                        end
                    end
                end

                ST_RUN: begin
                    // Write stage: retire the grant taken on the previous edge.
                    sram_write <= pending;
                    if (pending) begin
                        sram_address   <= base_addr + ADDR_W'(lat_lane)
                                          + ADDR_W'(NUM_LANES) * ADDR_W'(lat_cnt);
                        sram_writedata <= rgb332(lat_iter, max_iterations);
                        cnt[lat_lane]  <= cnt[lat_lane] + CNT_W'(1);
                    end

                    if (|exhausted_valid) begin
                        overflow <= 1'b1;
                    end

                    // Grant stage: ack the chosen lane and capture its result.
                    res_ack <= grant_onehot;
                    pending <= grant_valid;
                    if (grant_valid) begin
                        lat_lane <= grant_lane;
                        lat_iter <= grant_iter;
                        lat_cnt  <= grant_cnt;
                        ptr      <= ptr_next;
                    end

                    // Counters only reach full once the final write has been
                    // issued, so checking pending as well waits for it to drain.
                    if (all_full && !pending) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixel_writeback_arbiter
//
// Self-checking bench for pixel_writeback_arbiter (4 lanes, 3 pixels per
// lane). Lanes are modelled as result queues that hold valid/data until
// acked. A cycle-level reference model built from counters and queues
// predicts acks, writes and status flags, and one negedge process compares
// the DUT against it every cycle. Directed frames add literal expectations
// for addresses, colours, grant order, done latency, overflow and reset.
// ---------------------------------------------------------------------------
module tb_pixel_writeback_arbiter;

    localparam int NL  = 4;
    localparam int IW  = 16;
    localparam int AW  = 16;
    localparam int PPL = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [IW-1:0]    max_iterations;
    logic [NL-1:0]    res_valid;
    logic [NL*IW-1:0] res_iter;
    logic [NL-1:0]    res_ack;
    logic [AW-1:0]    sram_address;
    logic [7:0]       sram_writedata;
    logic             sram_write;
    logic             sram_clken;
    logic             sram_chipselect;
    logic             busy;
    logic             done;
    logic             overflow;

    pixel_writeback_arbiter #(
        .NUM_LANES      (NL),
        .ITER_W         (IW),
        .ADDR_W         (AW),
        .PIXELS_PER_LANE(PPL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .max_iterations (max_iterations),
        .res_valid      (res_valid),
        .res_iter       (res_iter),
        .res_ack        (res_ack),
        .sram_address   (sram_address),
        .sram_writedata (sram_writedata),
        .sram_write     (sram_write),
        .sram_clken     (sram_clken),
        .sram_chipselect(sram_chipselect),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t wlog[$];
    int  glog[$];

    // Lane behaviour
    logic [IW-1:0] lane_q[NL][$];
    bit            stale[NL];
    int            lane_prob[NL];

    // Reference model state
    bit            model_ready = 1'b0;
    int            m_state;
    int            wr[NL];
    int            pre[NL];
    int            ptr_m;
    bit            pend;
    int            pend_lane;
    int            pend_n;
    logic [IW-1:0] pend_iter;
    logic [NL-1:0] e_ack;
    bit            e_write, e_busy, e_done, e_ovf, e_after_rst;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    int            g;
    int            kk;
    bit            all_full;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_colour(input logic [IW-1:0] it, input logic [IW-1:0] m);
        int unsigned mi = m;
        int unsigned ii = it;
        if (ii >= mi)      return 8'h00;
        if (ii >= mi / 2)  return 8'h64;
        if (ii >= mi / 4)  return 8'h64;
        if (ii >= mi / 8)  return 8'hA9;
        if (ii >= mi / 16) return 8'h65;
        if (ii >= mi / 32) return 8'h25;
        if (ii >= mi / 64) return 8'h6A;
        return 8'h92;
    endfunction

    function automatic logic [IW-1:0] lane_iter(input int k);
        logic [IW-1:0] v = '0;
        for (int j = 0; j < NL; j++) begin
            if (j == k) v = res_iter[j*IW +: IW];
        end
        return v;
    endfunction

    // Compare DUT against the model, then advance the model by one edge
    // using the inputs that the DUT will sample at the next posedge.
    always @(negedge clk) begin
        if (model_ready) begin
            check_output("res_ack", res_ack, e_ack);
            check_output("sram_write", sram_write, e_write);
            if (e_write) begin
                check_output("sram_address", sram_address, e_addr);
                check_output("sram_writedata", sram_writedata, e_data);
            end
            if (e_after_rst) begin
                check_output("rst_address", sram_address, 0);
                check_output("rst_writedata", sram_writedata, 0);
            end
            check_output("busy", busy, e_busy);
            check_output("done", done, e_done);
            check_output("overflow", overflow, e_ovf);
            check_output("clken_chipselect", {sram_clken, sram_chipselect}, 2'b11);
            if (sram_write) wlog.push_back('{addr: sram_address, data: sram_writedata});
            for (int k = 0; k < NL; k++) if (res_ack[k]) glog.push_back(k);
        end

        e_after_rst = 1'b0;
        if (rst) begin
            m_state = 0; ptr_m = 0; pend = 1'b0;
            for (int k = 0; k < NL; k++) wr[k] = 0;
            e_ack = '0; e_write = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
            e_addr = '0; e_data = '0; e_after_rst = 1'b1;
            model_ready = 1'b1;
        end else if (model_ready) begin
            if (m_state != 1) begin
                e_ack = '0;
                e_write = 1'b0;
                if (start) begin
                    m_state = 1; ptr_m = 0; e_ovf = 1'b0; e_busy = 1'b1; e_done = 1'b0;
                    for (int k = 0; k < NL; k++) wr[k] = 0;
                end
            end else begin
                pre = wr;
                all_full = 1'b1;
                for (int k = 0; k < NL; k++) begin
                    if (pre[k] != PPL) all_full = 1'b0;
                    if (res_valid[k] && pre[k] == PPL) e_ovf = 1'b1;
                end
                e_write = pend;
                if (pend) begin
                    e_addr = base_addr + AW'(pend_lane) + AW'(NL * pend_n);
                    e_data = exp_colour(pend_iter, max_iterations);
                    wr[pend_lane]++;
                end
                g = -1;
                for (int i = 0; i < NL; i++) begin
                    kk = (ptr_m + i) % NL;
                    if (g < 0 && res_valid[kk] && pre[kk] < PPL && !e_ack[kk]) g = kk;
                end
                e_ack = '0;
                if (all_full && !pend) begin
                    m_state = 2; e_busy = 1'b0; e_done = 1'b1; pend = 1'b0;
                end else begin
                    pend = (g >= 0);
                    if (g >= 0) begin
                        e_ack[g]  = 1'b1;
                        pend_lane = g;
                        pend_iter = lane_iter(g);
                        pend_n    = pre[g];
                        ptr_m     = (g + 1) % NL;
                    end
                end
            end
        end
    end

    // One clock of lane behaviour: consume on ack, hold until acked, offer
    // the next result from the cycle after the ack onward.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            if (res_ack[k]) begin
                if (lane_q[k].size() > 0) void'(lane_q[k].pop_front());
                stale[k] = 1'b1;
            end else if (stale[k] || !res_valid[k]) begin
                stale[k] = 1'b0;
                if (lane_q[k].size() > 0 && int'($urandom_range(0, 99)) < lane_prob[k]) begin
                    res_valid[k] = 1'b1;
                    res_iter[k*IW +: IW] = lane_q[k][0];
                end else begin
                    res_valid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic reset_lanes();
        for (int k = 0; k < NL; k++) begin
            lane_q[k].delete();
            stale[k] = 1'b0;
            res_valid[k] = 1'b0;
        end
    endtask

    function automatic logic [IW-1:0] rand_iter(input logic [IW-1:0] m);
        int s = int'($urandom_range(0, 9));
        if (s >= 8) return IW'($urandom);
        return (m >> s) + IW'($urandom_range(0, 2)) - IW'(1);
    endfunction

    task automatic fill_lane(input int k, input int n, input logic [IW-1:0] m, input int prob);
        for (int i = 0; i < n; i++) lane_q[k].push_back(rand_iter(m));
        lane_prob[k] = prob;
    endtask

    task automatic start_frame();
        start = 1'b1;
        apply_stimulus();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            apply_stimulus();
            n++;
        end
        check_output("wait_done", done, 1);
    endtask

    task automatic wait_writes(input int target, input int limit);
        int n = 0;
        while (wlog.size() < target && n < limit) begin
            apply_stimulus();
            n++;
        end
        check_output("wait_writes", wlog.size() >= target, 1);
    endtask

    task automatic check_write(input string name, input int from,
                               input logic [AW-1:0] addr, input logic [7:0] exp);
        longint act = 64'hFFFF;
        for (int i = from; i < wlog.size(); i++) begin
            if (wlog[i].addr == addr) act = wlog[i].data;
        end
        check_output(name, act, exp);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int from;
        int gfrom;
        int n;
        logic [IW-1:0] m;

        rst = 1'b1; start = 1'b0; base_addr = '0; max_iterations = '0;
        res_valid = '0; res_iter = '0;
        for (int k = 0; k < NL; k++) begin stale[k] = 1'b0; lane_prob[k] = 100; end
        repeat (3) apply_stimulus();
        rst = 1'b0;
        apply_stimulus();
        check_output("reset_state", {busy, done, overflow, sram_write}, 4'b0000);
        check_output("reset_ack", res_ack, 0);

        // Frame A: lane 0 alone first, then the rest finish the frame.
        $display("[TB] frame A: single lane addressing and colours");
        base_addr = 16'h0100; max_iterations = 16'd1000;
        lane_q[0] = '{16'd1000, 16'd600, 16'd5}; lane_prob[0] = 100;
        from = wlog.size();
        start_frame();
        wait_writes(from + 3, 50);
        check_write("A_0x100", from, 16'h0100, 8'h00);
        check_write("A_0x104", from, 16'h0104, 8'h64);
        check_write("A_0x108", from, 16'h0108, 8'h92);
        for (int k = 1; k < NL; k++) fill_lane(k, PPL, max_iterations, 60);
        wait_done(200);

        // Frame B: all lanes continuously valid, restart from DONE.
        $display("[TB] frame B: continuous round-robin");
        base_addr = 16'h0200; max_iterations = 16'd500;
        for (int k = 0; k < NL; k++) fill_lane(k, PPL, max_iterations, 100);
        apply_stimulus();
        from = wlog.size(); gfrom = glog.size();
        start_frame();
        check_output("B_restart_done_low", done, 0);
        check_output("B_restart_busy", busy, 1);
        n = 0;
        while (!done && n < 60) begin
            start = (n == 5);
            apply_stimulus();
            n++;
        end
        start = 1'b0;
        check_output("B_done_latency", n, 14);
        for (int i = 0; i < NL * PPL; i++) begin
            check_output("B_grant_order", (glog.size() > gfrom + i) ? glog[gfrom + i] : -1, i % NL);
            check_output("B_write_addr", (wlog.size() > from + i) ? longint'(wlog[from + i].addr) : -1,
                         16'h0200 + i);
        end

        // Frame C: lane 2 offers one result too many.
        $display("[TB] frame C: overflow");
        base_addr = 16'h0300; max_iterations = 16'd777;
        for (int k = 0; k < NL; k++) fill_lane(k, (k == 2) ? PPL + 1 : PPL, max_iterations,
                                               (k == 2) ? 100 : 40);
        apply_stimulus();
        start_frame();
        wait_done(300);
        repeat (3) apply_stimulus();
        check_output("C_overflow_sticky", overflow, 1);
        check_output("C_lane2_held", res_valid[2], 1);
        reset_lanes();

        // Frame D: restart clears overflow, then reset mid-frame.
        $display("[TB] frame D: reset mid-frame");
        base_addr = 16'h0400; max_iterations = 16'd300;
        for (int k = 0; k < NL; k++) fill_lane(k, PPL, max_iterations, 100);
        apply_stimulus();
        from = wlog.size();
        start_frame();
        check_output("D_overflow_cleared", overflow, 0);
        check_output("D_done_cleared", done, 0);
        wait_writes(from + 3, 50);
        rst = 1'b1; start = 1'b1;
        apply_stimulus();
        check_output("D_rst_write", sram_write, 0);
        check_output("D_rst_state", {busy, done, overflow}, 3'b000);
        rst = 1'b0; start = 1'b0;
        reset_lanes();
        lane_q[0].push_back(16'd300);
        fill_lane(0, PPL - 1, max_iterations, 100);
        for (int k = 1; k < NL; k++) fill_lane(k, PPL, max_iterations, 100);
        repeat (3) apply_stimulus();
        check_output("D_idle_no_write", {busy, sram_write}, 2'b00);
        from = wlog.size();
        start_frame();
        wait_done(200);
        check_output("D_first_addr", (wlog.size() > from) ? longint'(wlog[from].addr) : -1, 16'h0400);
        check_write("D_first_data", from, 16'h0400, 8'h00);

        // Frame E: colour thresholds with m=256, then m=0.
        $display("[TB] frame E: colour edges");
        base_addr = 16'h0000; max_iterations = 16'd256;
        lane_q[0] = '{16'd256, 16'd128, 16'd32};
        lane_q[1] = '{16'd4, 16'd3, 16'd0};
        lane_q[2] = '{16'd0, 16'd0, 16'd0};
        lane_q[3] = '{16'd0, 16'd0, 16'd0};
        for (int k = 0; k < NL; k++) lane_prob[k] = 80;
        apply_stimulus();
        from = wlog.size();
        start_frame();
        wait_done(200);
        check_write("E_256", from, 16'h0000, 8'h00);
        check_write("E_128", from, 16'h0004, 8'h64);
        check_write("E_32",  from, 16'h0008, 8'hA9);
        check_write("E_4",   from, 16'h0001, 8'h6A);
        check_write("E_3",   from, 16'h0005, 8'h92);
        max_iterations = 16'd0;
        for (int k = 0; k < NL; k++) fill_lane(k, PPL, 16'd0, 70);
        lane_q[0][0] = 16'd0;
        apply_stimulus();
        from = wlog.size();
        start_frame();
        wait_done(200);
        check_write("E_m0", from, 16'h0000, 8'h00);

        // Random frames against the model.
        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            reset_lanes();
            base_addr = AW'($urandom);
            m = IW'($urandom_range(0, 4000));
            max_iterations = m;
            for (int k = 0; k < NL; k++)
                fill_lane(k, PPL + (($urandom_range(0, 4) == 0) ? 1 : 0), m,
                          int'($urandom_range(30, 100)));
            apply_stimulus();
            start_frame();
            wait_done(400);
        end
        reset_lanes();
        repeat (2) apply_stimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
